// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store bridge.
// Holds the dm_type encodings, the FSM state encoding, and the width
// derivation for the optional bus timeout counter (LSU_TIMEOUT_EN).
package lsu_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  // Bits needed to count 0..n inclusive, never less than one.
  function automatic int lsu_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store bridge.
// Store side positions write data and byte enables for the access size and
// flags misaligned accesses; load side extracts and extends the addressed
// byte/half from the bus word. Unknown dm_type codes behave as word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_dm_type,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane_wdata,
  output logic        o_misalign,
  input  logic [31:0] i_bus_rdata,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_dm_type,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte enables, replicated lane data and alignment check for the request
  always_comb begin
    o_be         = 4'b1111;
    o_lane_wdata = i_wdata;
    o_misalign   = 1'b0;
    case (i_dm_type)
      DM_HALF, DM_HALF_U: begin
        o_be         = i_off[1] ? 4'b1100 : 4'b0011;
        o_lane_wdata = {2{i_wdata[15:0]}};
        o_misalign   = i_off[0];
      end
      DM_BYTE, DM_BYTE_U: begin
        o_be         = 4'b0001 << i_off;
        o_lane_wdata = {4{i_wdata[7:0]}};
      end
      default: o_misalign = |i_off;
    endcase
  end

  assign w_byte = i_bus_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_ld_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

  // Select the addressed lane of the read word and sign/zero extend it
  always_comb begin
    o_ld_data = i_bus_rdata;
    case (i_ld_dm_type)
      DM_HALF:   o_ld_data = {{16{w_half[15]}}, w_half};
      DM_HALF_U: o_ld_data = {16'h0000, w_half};
      DM_BYTE:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      DM_BYTE_U: o_ld_data = {24'h000000, w_byte};
      default:   o_ld_data = i_bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bridge.sv
// lsu_bridge: load/store unit between the CPU decoder and a req/ack bus.
// Accepts one access in IDLE, holds a registered bus request in ACCESS until
// bus_ack, then spends one DONE cycle with stall low so the CPU commits.
// Optional build macro LSU_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES
// cycles without ack and pulse bus_err; without it bus_err is tied 0.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; inputs sampled here only
// ACCESS | bus_req held with stable payload until ack (or timeout)
// DONE   | one cycle, stall low, result visible on rdata
module lsu_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_t  r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [2:0]  r_dm_type;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_misalign;

  logic        w_access;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;
  logic        w_misalign;
  logic [31:0] w_ld_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = lsu_cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

  assign w_access = mem_read | mem_write;

  lsu_align u_align (
    .i_off        (addr[1:0]),
    .i_dm_type    (dm_type),
    .i_wdata      (wdata),
    .o_be         (w_be),
    .o_lane_wdata (w_lane_wdata),
    .o_misalign   (w_misalign),
    .i_bus_rdata  (bus_rdata),
    .i_ld_off     (r_off),
    .i_ld_dm_type (r_dm_type),
    .o_ld_data    (w_ld_data)
  );

  // Stall is combinational so the cycle that presents the access already holds the PC
  assign stall = ~rst & (((r_state == ST_IDLE) & w_access) | (r_state == ST_ACCESS));

  // Sequencing FSM with registered bus payload and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_dm_type   <= DM_WORD;
      r_off       <= '0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_bus_err  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_misalign) begin
              r_state    <= ST_DONE;
              r_misalign <= 1'b1;
              r_rdata    <= '0;
            end else begin
              r_state     <= ST_ACCESS;
              r_bus_req   <= 1'b1;
              r_bus_we    <= mem_write;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_lane_wdata;
              r_dm_type   <= dm_type;
              r_off       <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
              r_cnt       <= '0;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) r_rdata <= w_ld_data;
            r_state   <= ST_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign misalign  = r_misalign;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bridge.sv
// tb_lsu_bridge: randomized and directed bench for lsu_bridge with a
// transaction-level reference model. Build with LSU_TIMEOUT_EN to also
// exercise the bus timeout (TIMEOUT_CYCLES = 4).
module tb_lsu_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  dm_type = 3'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  lsu_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .dm_type(dm_type), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  // expectations for the current cycle
  logic        exp_stall = 0, exp_req = 0, exp_mis = 0, exp_err = 0, exp_we = 0;
  logic [31:0] exp_rdata = 0, exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] m_rdata = 0;

  int stall_cnt, req_cnt, mis_cnt, err_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference rules, written from the access-size view
  function automatic int size_of(input logic [2:0] dm);
    if (dm == 3'd1 || dm == 3'd2) return 2;
    if (dm == 3'd3 || dm == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] dm, input logic [1:0] k);
    logic [3:0] be = '0;
    int s = size_of(dm);
    for (int b = 0; b < 4; b++) be[b] = (b >= int'(k)) && (b < int'(k) + s);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] dm, input logic [31:0] wd);
    logic [31:0] v = '0;
    int s = size_of(dm);
    for (int b = 0; b < 4; b++) v[8*b +: 8] = wd[8*(b % s) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] dm, input logic [1:0] k,
                                             input logic [31:0] w);
    logic [31:0] v, mask;
    int s = size_of(dm);
    v = w >> (8 * int'(k));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v = v & mask;
    if ((dm == 3'd1 || dm == 3'd3) && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // single compare process, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
      chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
      chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
      chk("rdata", rdata, exp_rdata);
      if (exp_req) begin
        chk("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
        chk("bus_wdata", bus_wdata, exp_wdata);
      end
      if (stall) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata;
      end
      if (misalign) mis_cnt++;
      if (bus_err) err_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    dm_type   = 3'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
  endtask

  task automatic idle_exp();
    mem_read = 0; mem_write = 0; bus_ack = 0;
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_err = 0; exp_rdata = m_rdata;
  endtask

  // one access; n_wait = ACCESS cycles before the ack cycle
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] dm,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rword, input int n_wait);
    logic [1:0] k = a[1:0];
    bit mis = (int'(k) % size_of(dm)) != 0;
    cyc();
    mem_read = rd; mem_write = wr; dm_type = dm; addr = a; wdata = wd;
    bus_ack = 0; bus_rdata = $urandom;
    stall_cnt = 0; req_cnt = 0; mis_cnt = 0; err_cnt = 0;
    exp_stall = 1; exp_req = 0; exp_mis = 0; exp_err = 0; exp_rdata = m_rdata;
    exp_we = wr; exp_addr = {a[31:2], 2'b00}; exp_be = model_be(dm, k);
    exp_wdata = model_wdata(dm, wd);
    if (mis) begin
      cyc();
      rand_inputs();
      m_rdata = 0;
      exp_stall = 0; exp_mis = 1; exp_rdata = 0;
    end else begin
      for (int i = 0; i <= n_wait; i++) begin
        cyc();
        rand_inputs();
        bus_ack = (i == n_wait);
        bus_rdata = (i == n_wait) ? rword : $urandom;
        exp_stall = 1; exp_req = 1;
      end
      cyc();
      rand_inputs();
      bus_ack = 0; bus_rdata = $urandom;
      if (!wr) m_rdata = model_load(dm, k, rword);
      exp_stall = 0; exp_req = 0; exp_rdata = m_rdata;
    end
    cyc();
    idle_exp();
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    cyc(); cyc();
    rst = 0;

    // sb at 0x1003
    do_txn(0, 1, 3'd3, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    chk("sb_addr", cap_addr, 32'h0000_1000);
    chk("sb_be", {28'd0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_stall_cycles", stall_cnt, 2);

    // lb / lbu / lh / lhu
    do_txn(1, 0, 3'd3, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    do_txn(1, 0, 3'd4, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    do_txn(1, 0, 3'd1, 32'h0000_2002, 32'h0, 32'h1234_80FF, 0);
    chk("lh_rdata", rdata, 32'h0000_1234);
    do_txn(1, 0, 3'd2, 32'h0000_2002, 32'h0, 32'h1234_80FF, 2);
    chk("lhu_rdata", rdata, 32'h0000_1234);

    // lw, ack in the fifth cycle after the access
    do_txn(1, 0, 3'd0, 32'h0000_4008, 32'h0, 32'hCAFE_BABE, 4);
    chk("lw_stall_cycles", stall_cnt, 6);
    chk("lw_req_cycles", req_cnt, 5);
    chk("lw_rdata", rdata, 32'hCAFE_BABE);

    // misaligned sh
    do_txn(0, 1, 3'd1, 32'h0000_3001, 32'h1111_2222, 32'h0, 0);
    chk("mis_req_cycles", req_cnt, 0);
    chk("mis_pulses", mis_cnt, 1);
    chk("mis_stall_cycles", stall_cnt, 1);
    chk("mis_rdata", rdata, 32'h0);

    // reset in the middle of ACCESS
    do_txn(1, 0, 3'd0, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 0);
    cyc();
    mem_read = 1; mem_write = 0; dm_type = 3'd0; addr = 32'h0000_6000;
    exp_stall = 1; exp_req = 0; exp_rdata = m_rdata; exp_mis = 0; exp_err = 0;
    cyc();
    mem_read = 0; bus_ack = 0;
    exp_stall = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h0000_6000;
    exp_be = 4'hF; exp_wdata = wdata;
    #2;
    rst = 1;
    m_rdata = 0;
    exp_stall = 0; exp_req = 0; exp_rdata = 0;
    #1;
    chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    cyc();
    rst = 0;
    do_txn(1, 0, 3'd0, 32'h0000_7004, 32'h0, 32'h7777_0001, 1);
    chk("post_rst_lw", rdata, 32'h7777_0001);

`ifdef LSU_TIMEOUT_EN
    // no ack: four request cycles then bus_err
    do_txn(1, 0, 3'd0, 32'h0000_8000, 32'h0, 32'h5555_5555, 0);
    cyc();
    mem_read = 1; dm_type = 3'd0; addr = 32'h0000_9000;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0;
    exp_stall = 1; exp_req = 0; exp_rdata = m_rdata;
    for (int i = 0; i < 4; i++) begin
      cyc();
      rand_inputs(); bus_ack = 0;
      exp_stall = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h0000_9000; exp_be = 4'hF;
    end
    cyc();
    rand_inputs();
    m_rdata = 0;
    exp_stall = 0; exp_req = 0; exp_err = 1; exp_rdata = 0;
    cyc();
    idle_exp();
    chk("to_req_cycles", req_cnt, 4);
    chk("to_err_pulses", err_cnt, 1);
    chk("to_rdata", rdata, 32'h0);
`endif

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      logic rd, wr;
      logic [2:0] dm;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1;
      dm = 3'($urandom);
      do_txn(rd, wr, dm, $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        cyc();
        idle_exp();
      end
    end

    cyc();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_bridge.md
Name: lsu_bridge

Overview:
- Load/store unit sitting directly downstream of the CPU control decoder; consumes MemWrite, mem_read and DMType plus ALU address and rs2 data.
- Converts byte/halfword/word accesses into word-aligned, byte-enabled transactions on a req/ack memory bus.
- Stalls the single-cycle datapath until the transaction completes, then returns sign- or zero-extended load data for register write-back.

Parameters:
- TIMEOUT_CYCLES, 16: bus cycles waited for bus_ack before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- dm_type  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data for write-back
- stall  out  1  hold PC and suppress RegWrite this cycle
- misalign  out  1  one-cycle pulse: misaligned access dropped
- bus_err  out  1  one-cycle pulse: bus timeout (LSU_TIMEOUT_EN only, else tied 0)
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, bits [1:0] = 00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-positioned write data
- bus_ack  in  1  transaction complete; bus_rdata valid same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset: all registered outputs are 0. State is IDLE and the timeout counter is cleared. Applies immediately and asynchronously, including mid-transaction; bus_req drops without waiting for ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with (mem_read|mem_write):
  - stall = 1 combinationally.
  - Aligned access: register bus_addr = {addr[31:2],2'b00}, bus_be, bus_wdata, bus_we = mem_write, the dm_type copy and addr[1:0]; next state ACCESS.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]!=0): no bus transaction, no write; next state DONE with misalign=1 and rdata=0.
- IDLE with no access: stall=0, rdata holds its previous value.
- ACCESS: bus_req=1 and stall=1. On bus_ack, latch the extended load data into rdata (stores leave rdata unchanged), drop bus_req, next state DONE. bus_req and payload stay stable until ack.
- DONE: exactly one cycle with stall=0; the CPU commits at the end of this cycle. Next state is IDLE, so back-to-back memory instructions each start from IDLE.
- mem_read and mem_write both high: treated as a store. dm_type 101–111 is treated as word.
- Minimum latency: access seen in cycle 0, ack in cycle 1, DONE in cycle 2. stall is high for 2 cycles.
- Store lanes, k = addr[1:0]:
  - byte: be = 1<<k, wdata[7:0] replicated to all four bytes.
  - half: be = 0011 for k=0, 1100 for k=2; wdata[15:0] replicated.
  - word: be = 1111.
- Load extract: select byte lane k or half lane k[1]. Sign-extend for types 001/011; zero-extend for 010/100; word passes through.
- Inputs are sampled only in IDLE; changes during ACCESS are ignored.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter increments each ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop bus_req, pulse bus_err in DONE, rdata=0, go to DONE.
  - Counter clears on entering ACCESS.
- Undefined: no counter; ACCESS waits indefinitely; bus_err tied 0.

Decomposition:
- Package lsu_pkg holds the dm_type constants (DM_WORD..DM_BYTE_U), the FSM state encoding, and TIMEOUT width derivation.
- One combinational sub-module, lsu_align:
  - store side: addr[1:0], dm_type, wdata -> be, lane data, misaligned flag.
  - load side: bus word, addr[1:0], dm_type -> extended data.
- The FSM, output registers and counter remain in lsu_bridge.

Test Plan:
- sb: addr=0x1003, wdata=0x000000A5, ack in 1st ACCESS cycle -> bus_addr=0x1000, be=1000, bus_wdata=0xA5A5A5A5, stall high 2 cycles.
- lb/lbu: addr=0x2001, bus_rdata=0x1234_80FF -> lb rdata=0xFFFFFF80, lbu rdata=0x00000080; lh/lhu at 0x2002 -> 0x00001234 for both.
- lw with ack delayed 5 cycles -> bus_req and payload stable throughout, stall high 6 cycles, rdata = bus_rdata in DONE.
- Misaligned sh at addr=0x3001 -> no bus_req, misalign pulse in cycle 1, stall high 1 cycle, no write.
- rst asserted during ACCESS -> bus_req=0, stall=0 and rdata=0 immediately; the next load after release completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, then bus_err pulse, rdata=0, return to IDLE.
